// File: rtl/parking_slot_allocator.sv
// Two-lot parking slot allocator: four-phase entry/exit gates arbitrated onto one occupancy table.
// Optional PARK_FEE_EN adds per-slot duration counters and a fee output on exit.
module parking_slot_allocator #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 3,
  parameter int TICK_DIV  = 100,
  parameter int RATE      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           lot_sel,
  input  logic                 entry_req,
  output logic                 entry_ack,
  output logic                 entry_ok,
  output logic [SLOT_W-1:0]    entry_slot,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_slot_in,
  output logic                 exit_ack,
  output logic                 exit_ok,
  output logic [NUM_SLOTS-1:0] occ_view,
  output logic [SLOT_W:0]      free_cnt,
  output logic [1:0]           full
`ifdef PARK_FEE_EN
  ,
  output logic [15:0]          fee,
  output logic                 fee_valid
`endif
);

  typedef enum logic [1:0] {IDLE, CAPTURE, EXEC, RESP} state_t;

  state_t                state_reg, state_next;
  logic [NUM_SLOTS-1:0]  occ_reg [2];
  logic                  is_exit_reg, rr_exit_reg, lot_reg;
  logic [SLOT_W-1:0]     slot_reg;
  logic                  entry_ack_reg, entry_ok_reg, exit_ack_reg, exit_ok_reg;
  logic [SLOT_W-1:0]     entry_slot_reg;

  logic                  entry_pend, exit_pend, tie, lot_ok;
  logic                  accept_entry, accept_exit;
  logic [NUM_SLOTS-1:0]  cur_occ;
  logic                  free_found;
  logic [SLOT_W-1:0]     free_idx;
  logic                  slot_in_range, exit_hit;

  assign entry_pend    = entry_req && !entry_ack_reg;
  assign exit_pend     = exit_req && !exit_ack_reg;
  assign tie           = entry_pend && exit_pend;
  assign lot_ok        = (lot_sel == 3'd1) || (lot_sel == 3'd2);
  assign cur_occ       = occ_reg[lot_reg];
  assign slot_in_range = {1'b0, slot_reg} < (SLOT_W+1)'(NUM_SLOTS);
  assign exit_hit      = slot_in_range && cur_occ[slot_reg];

  // Lowest-numbered free slot of the latched lot
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!cur_occ[i]) begin
        free_found = 1'b1;
        free_idx   = SLOT_W'(i);
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    accept_entry = 1'b0;
    accept_exit  = 1'b0;
    case (state_reg)
      IDLE: begin
        // rr_exit_reg set means exit won the last tie, so entry wins this one
        if (tie) begin
          accept_entry = rr_exit_reg;
          accept_exit  = !rr_exit_reg;
        end else begin
          accept_entry = entry_pend;
          accept_exit  = exit_pend;
        end
        if (accept_entry || accept_exit) state_next = CAPTURE;
      end
      CAPTURE: state_next = lot_ok ? EXEC : RESP;
      EXEC:    state_next = RESP;
      RESP:    if (is_exit_reg ? !exit_req : !entry_req) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      occ_reg[0]     <= '0;
      occ_reg[1]     <= '0;
      is_exit_reg    <= 1'b0;
      rr_exit_reg    <= 1'b1;
      lot_reg        <= 1'b0;
      slot_reg       <= '0;
      entry_ack_reg  <= 1'b0;
      entry_ok_reg   <= 1'b0;
      entry_slot_reg <= '0;
      exit_ack_reg   <= 1'b0;
      exit_ok_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept_entry || accept_exit) begin
        is_exit_reg <= accept_exit;
        if (tie) rr_exit_reg <= accept_exit;
      end
      case (state_reg)
        CAPTURE: begin
          lot_reg  <= (lot_sel == 3'd2);
          slot_reg <= exit_slot_in;
          if (!lot_ok) begin
            if (is_exit_reg) begin
              exit_ok_reg  <= 1'b0;
              exit_ack_reg <= 1'b1;
            end else begin
              entry_ok_reg   <= 1'b0;
              entry_slot_reg <= '0;
              entry_ack_reg  <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (is_exit_reg) begin
            exit_ack_reg <= 1'b1;
            exit_ok_reg  <= exit_hit;
            if (exit_hit) occ_reg[lot_reg][slot_reg] <= 1'b0;
          end else begin
            entry_ack_reg  <= 1'b1;
            entry_ok_reg   <= free_found;
            entry_slot_reg <= free_found ? free_idx : '0;
            if (free_found) occ_reg[lot_reg][free_idx] <= 1'b1;
          end
        end
        RESP: begin
          if (state_next == IDLE) begin
            entry_ack_reg <= 1'b0;
            exit_ack_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered free counts and full flags, one cycle behind the table
  for (genvar gi = 0; gi < 2; gi++) begin : g_lot
    logic [SLOT_W:0] cnt;
    logic [SLOT_W:0] free_reg;
    logic            full_reg;

    always_comb begin
      cnt = (SLOT_W+1)'(NUM_SLOTS);
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (occ_reg[gi][i]) cnt = cnt - (SLOT_W+1)'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        free_reg <= (SLOT_W+1)'(NUM_SLOTS);
        full_reg <= 1'b0;
      end else begin
        free_reg <= cnt;
        full_reg <= (cnt == '0);
      end
    end
  end

  always_comb begin
    occ_view = '0;
    free_cnt = '0;
    if (lot_sel == 3'd1) begin
      occ_view = occ_reg[0];
      free_cnt = g_lot[0].free_reg;
    end else if (lot_sel == 3'd2) begin
      occ_view = occ_reg[1];
      free_cnt = g_lot[1].free_reg;
    end
  end

  assign full       = {g_lot[1].full_reg, g_lot[0].full_reg};
  assign entry_ack  = entry_ack_reg;
  assign entry_ok   = entry_ok_reg;
  assign entry_slot = entry_slot_reg;
  assign exit_ack   = exit_ack_reg;
  assign exit_ok    = exit_ok_reg;

`ifdef PARK_FEE_EN
  logic [15:0] presc_reg;
  logic        tick;
  logic [7:0]  tick_arr [2][NUM_SLOTS];
  logic [15:0] fee_reg;
  logic        fee_valid_reg;

  assign tick = (presc_reg == 16'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) presc_reg <= '0;
    else             presc_reg <= presc_reg + 16'd1;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_fee_lot
    for (genvar gj = 0; gj < NUM_SLOTS; gj++) begin : g_slot
      logic [7:0] ticks_reg;
      logic       grant;

      assign grant = (state_reg == EXEC) && !is_exit_reg && free_found &&
                     (lot_reg == 1'(gi)) && (free_idx == SLOT_W'(gj));

      always_ff @(posedge clk) begin
        if (rst || grant)
          ticks_reg <= '0;
        else if (tick && occ_reg[gi][gj] && ticks_reg != 8'hff)
          ticks_reg <= ticks_reg + 8'd1;
      end

      assign tick_arr[gi][gj] = ticks_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fee_reg       <= '0;
      fee_valid_reg <= 1'b0;
    end else if (state_reg == CAPTURE && is_exit_reg && !lot_ok) begin
      fee_reg       <= '0;
      fee_valid_reg <= 1'b0;
    end else if (state_reg == EXEC && is_exit_reg) begin
      fee_reg       <= exit_hit ? 16'(tick_arr[lot_reg][slot_reg]) * 16'(RATE) : '0;
      fee_valid_reg <= exit_hit;
    end else if (state_reg == RESP && state_next == IDLE && is_exit_reg) begin
      fee_valid_reg <= 1'b0;
    end
  end

  assign fee       = fee_reg;
  assign fee_valid = fee_valid_reg;
`endif

endmodule

// File: tb/tb_parking_slot_allocator.sv
// Randomized self-checking bench for parking_slot_allocator against an array-based lot model.
module tb_parking_slot_allocator;
  localparam int NS = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    lot_sel;
  logic          entry_req, exit_req;
  logic          entry_ack, entry_ok, exit_ack, exit_ok;
  logic [2:0]    entry_slot, exit_slot_in;
  logic [NS-1:0] occ_view;
  logic [3:0]    free_cnt;
  logic [1:0]    full;
`ifdef PARK_FEE_EN
  logic [15:0]   fee;
  logic          fee_valid;
`endif

  parking_slot_allocator #(.NUM_SLOTS(NS), .SLOT_W(3)) dut (
    .clk(clk), .rst(rst), .lot_sel(lot_sel),
    .entry_req(entry_req), .entry_ack(entry_ack), .entry_ok(entry_ok), .entry_slot(entry_slot),
    .exit_req(exit_req), .exit_slot_in(exit_slot_in), .exit_ack(exit_ack), .exit_ok(exit_ok),
    .occ_view(occ_view), .free_cnt(free_cnt), .full(full)
`ifdef PARK_FEE_EN
    , .fee(fee), .fee_valid(fee_valid)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit model [2][NS];
  int ties = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < NS; i++) model[l][i] = 1'b0;
    ties = 0;
  endtask

  task automatic check_view(input int lot);
    int cnt0 = 0;
    int cnt1 = 0;
    logic [NS-1:0] exp_view;
    lot_sel = 3'(lot);
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      cnt0 += int'(model[0][i]);
      cnt1 += int'(model[1][i]);
      exp_view[i] = model[lot - 1][i];
    end
    chk("free_cnt", 32'(free_cnt), 32'(NS - ((lot == 2) ? cnt1 : cnt0)));
    chk("full", 32'(full), 32'({cnt1 == NS, cnt0 == NS}));
    chk("occ_view", 32'(occ_view), 32'(exp_view));
  endtask

  // Waits for the gate's ack with the request already raised, checks the result, completes the handshake.
  task automatic serve(input bit is_exit, input int lot, input int slot, input bit solo, input bit check_lat);
    int cyc = 0;
    bit valid = (lot == 1) || (lot == 2);
    int li = (lot == 2) ? 1 : 0;
    bit exp_ok = 1'b0;
    int exp_slot = 0;
    while (cyc < 20 && (is_exit ? exit_ack : entry_ack) !== 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (solo && cyc == 2) lot_sel = 3'($urandom_range(0, 7));
    end
    chk(is_exit ? "exit_ack" : "entry_ack", 32'(is_exit ? exit_ack : entry_ack), 32'd1);
    if (check_lat && valid) chk("latency", 32'(cyc), 32'd3);
    if (valid) begin
      if (!is_exit) begin
        for (int i = NS - 1; i >= 0; i--)
          if (!model[li][i]) begin
            exp_ok = 1'b1;
            exp_slot = i;
          end
        if (exp_ok) model[li][exp_slot] = 1'b1;
      end else if (slot < NS && model[li][slot]) begin
        exp_ok = 1'b1;
        model[li][slot] = 1'b0;
      end
    end
    if (is_exit) begin
      chk("exit_ok", 32'(exit_ok), 32'(exp_ok));
    end else begin
      chk("entry_ok", 32'(entry_ok), 32'(exp_ok));
      chk("entry_slot", 32'(entry_slot), 32'(exp_slot));
    end
    $display("%s lot=%0d slot=%0d -> ok=%0d entry_slot=%0d cycles=%0d",
             is_exit ? "exit " : "entry", lot, slot,
             is_exit ? exit_ok : entry_ok, entry_slot, cyc);
    if (is_exit) exit_req = 1'b0;
    else         entry_req = 1'b0;
    cyc = 0;
    while (cyc < 10 && (is_exit ? exit_ack : entry_ack) !== 1'b0) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("ack_drop", 32'(is_exit ? exit_ack : entry_ack), 32'd0);
    if (solo) check_view(valid ? lot : 1);
  endtask

  task automatic solo_txn(input bit is_exit, input int lot, input int slot);
    lot_sel = 3'(lot);
    exit_slot_in = 3'(slot);
    if (is_exit) exit_req = 1'b1;
    else         entry_req = 1'b1;
    serve(is_exit, lot, slot, 1'b1, 1'b1);
  endtask

  task automatic tie_txn(input int lot, input int slot);
    bit winner_exit = (ties % 2) == 1;
    ties++;
    lot_sel = 3'(lot);
    exit_slot_in = 3'(slot);
    entry_req = 1'b1;
    exit_req = 1'b1;
    serve(winner_exit, lot, slot, 1'b0, 1'b1);
    serve(!winner_exit, lot, slot, 1'b0, 1'b0);
    check_view(((lot == 1) || (lot == 2)) ? lot : 1);
  endtask

  initial begin
    int r, lot, slot, li;
    rst = 1'b1;
    lot_sel = 3'd1;
    entry_req = 1'b0;
    exit_req = 1'b0;
    exit_slot_in = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_entry_ack", 32'(entry_ack), 32'd0);
    chk("rst_exit_ack", 32'(exit_ack), 32'd0);
    chk("rst_entry_ok", 32'(entry_ok), 32'd0);
    chk("rst_exit_ok", 32'(exit_ok), 32'd0);
    chk("rst_entry_slot", 32'(entry_slot), 32'd0);
    check_view(1);
    check_view(2);

    // Lot 1: three entries
    for (int k = 0; k < 3; k++) solo_txn(1'b0, 1, 0);
    // Lot 2: fill then one too many
    for (int k = 0; k < 9; k++) solo_txn(1'b0, 2, 0);
    // Free slot 1 in lot 1 and reclaim it
    solo_txn(1'b1, 1, 1);
    solo_txn(1'b0, 1, 0);
    // Two ties: entry wins the first, exit the second
    tie_txn(1, 0);
    tie_txn(1, 3);
    // Exit of an empty slot, entry to an invalid lot
    solo_txn(1'b1, 1, 5);
    solo_txn(1'b0, 3, 0);
    solo_txn(1'b1, 0, 2);

    // Reset in the middle of an entry with the request held
    lot_sel = 3'd2;
    entry_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    serve(1'b0, 2, 0, 1'b1, 1'b1);
    check_view(1);

    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 99);
      lot = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : $urandom_range(3, 7))
                                        : $urandom_range(1, 2);
      slot = $urandom_range(0, NS - 1);
      li = (lot == 2) ? 1 : 0;
      if (r >= 50 && $urandom_range(0, 2) != 0) begin
        for (int i = 0; i < NS; i++)
          if (model[li][(slot + i) % NS]) begin
            slot = (slot + i) % NS;
            break;
          end
      end
      if (r < 50)      solo_txn(1'b0, lot, slot);
      else if (r < 85) solo_txn(1'b1, lot, slot);
      else             tie_txn(lot, slot);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
